// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   BR_BUS_W / FS_TO_DS_BUS_W : bus widths toward ID/EXE
//   IF_RESET_PC               : default first fetch address
//   BR_*_BIT                  : field positions inside br_bus
//   fs_entry_t                : one instruction-buffer entry {adef, inst, pc}
package if_pkg;
  localparam int BR_BUS_W       = 35;
  localparam int FS_TO_DS_BUS_W = 65;
  localparam logic [31:0] IF_RESET_PC = 32'h1C00_0000;

  // br_bus = {br_stall, br_taken_cancel, br_taken, br_target[31:0]}
  localparam int BR_STALL_BIT  = 34;
  localparam int BR_CANCEL_BIT = 33;
  localparam int BR_TAKEN_BIT  = 32;

  typedef struct packed {
    logic        adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_entry_t;
endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with occupancy count and flush.
//   clk, reset : clock, synchronous active-high reset
//   flush      : drop all entries (wins over push/pop)
//   push/din   : write an entry
//   pop        : retire the head (ignored when empty)
//   dout       : current head, read straight from storage
//   count      : number of valid entries; empty/full derived from it
// Depth need not be a power of two; pointers wrap explicitly.
module if_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             pop_en;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop_en = pop & ~empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= nxt(wr_ptr);
      if (pop_en) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop_en);
    end
  end

  // Callers guarantee a slot for every push and never pop an empty queue.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
    end
  end
endmodule

// File: rtl/if_stage_ibuf.sv
// Instruction-fetch stage with several outstanding inst_sram reads and an
// instruction buffer feeding ID.
//   clk, reset            : clock, synchronous active-high reset
//   ds_allowin            : ID takes the buffer head this cycle
//   br_bus                : {br_stall, br_taken_cancel, br_taken, br_target}
//   fs_to_ds_valid/bus    : buffer head {adef, inst, pc}
//   inst_sram_*           : read-only SRAM-like request/response port
//   wb_ex / wb_ertn       : exception / ertn commit, redirect to csr_eentry / csr_era
// Redirects flush the buffer and leave in-flight requests to be dropped by
// a discard counter as they return.
module if_stage_ibuf
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IF_RESET_PC,
  parameter int          MAX_OUTST  = 2,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ds_allowin,
  input  logic [BR_BUS_W-1:0]       br_bus,
  output logic                      fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
  output logic                      inst_sram_req,
  output logic                      inst_sram_wr,
  output logic [3:0]                inst_sram_wstrb,
  output logic [1:0]                inst_sram_size,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic [31:0]               inst_sram_rdata,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic                      wb_ex,
  input  logic                      wb_ertn,
  input  logic [31:0]               csr_eentry,
  input  logic [31:0]               csr_era
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int IW = $clog2(IBUF_DEPTH + 1);

  logic        br_stall, br_taken, redirect, handshake;
  logic [31:0] br_target, redirect_pc, fetch_pc, pcq_head;
  logic        halt, live_none, adef_push, data_push, ibuf_push, ibuf_pop;
  logic        ibuf_empty, ibuf_full, room;
  logic [OW-1:0] outst, discard;
  logic [IW-1:0] ibuf_count;
  fs_entry_t   ibuf_din, ibuf_head;
  logic        pcq_empty_unused, pcq_full_unused, cancel_unused;

  assign br_target     = br_bus[31:0];
  assign br_taken      = br_bus[BR_TAKEN_BIT];
  assign br_stall      = br_bus[BR_STALL_BIT];
  assign cancel_unused = br_bus[BR_CANCEL_BIT];

  assign redirect    = wb_ex | wb_ertn | (br_taken & ~br_stall);
  assign redirect_pc = wb_ex ? csr_eentry : wb_ertn ? csr_era : br_target;

  // Count outstanding reads against the buffer so every return has a slot.
  assign room = (int'(ibuf_count) + int'(outst)) < IBUF_DEPTH;
  assign inst_sram_req = ~reset & ~redirect & ~br_stall & ~halt
                       & (fetch_pc[1:0] == 2'b00)
                       & (int'(outst) < MAX_OUTST) & room;
  assign handshake = inst_sram_req & inst_sram_addr_ok;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_wstrb = 4'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_addr  = fetch_pc;
  assign inst_sram_wdata = 32'b0;

  // Misaligned pc raises ADEF only once nothing live is still in flight,
  // so it lands in the buffer after all older instructions.
  assign live_none = (outst == discard);
  assign adef_push = ~reset & ~redirect & ~halt & (fetch_pc[1:0] != 2'b00)
                   & live_none & ~ibuf_full;
  assign data_push = inst_sram_data_ok & (discard == '0) & ~redirect;
  assign ibuf_push = adef_push | data_push;
  assign ibuf_pop  = ds_allowin & ~ibuf_empty & ~redirect;

  always_comb begin
    ibuf_din = '{adef: 1'b0, inst: inst_sram_rdata, pc: pcq_head};
    if (adef_push) ibuf_din = '{adef: 1'b1, inst: 32'b0, pc: fetch_pc};
  end

  if_sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_pcq (
    .clk(clk), .reset(reset), .flush(1'b0),
    .push(handshake), .din(fetch_pc), .pop(inst_sram_data_ok),
    .dout(pcq_head), .count(outst),
    .empty(pcq_empty_unused), .full(pcq_full_unused)
  );

  if_sync_fifo #(.WIDTH(FS_TO_DS_BUS_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk(clk), .reset(reset), .flush(redirect),
    .push(ibuf_push), .din(ibuf_din), .pop(ibuf_pop),
    .dout(ibuf_head), .count(ibuf_count),
    .empty(ibuf_empty), .full(ibuf_full)
  );

  assign fs_to_ds_valid = ~ibuf_empty;
  assign fs_to_ds_bus   = ibuf_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
      halt     <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      // Everything still outstanding after this cycle belongs to the old path.
      discard  <= outst - OW'(inst_sram_data_ok);
      halt     <= 1'b0;
    end else begin
      if (handshake) fetch_pc <= fetch_pc + 32'd4;
      if (inst_sram_data_ok && discard != '0) discard <= discard - OW'(1);
      if (adef_push) halt <= 1'b1;
    end
  end
endmodule
